// File: rtl/qa1_input_conditioner.sv
// ---------------------------------------------------------------------------
// qa1_input_conditioner
//
// Conditions the board's raw toggle switches and push buttons for the qa1
// display logic. Each bit passes through a two-flop synchroniser and is then
// debounced on its own. A debounced bit changes only after STABLE_TICKS
// consecutive sample ticks that all disagree with the current level. All bits
// share one sample-tick prescaler.
//
// Parameters
//   WIDTH        number of conditioned inputs
//   TICK_DIV     clock cycles per sample tick (>= 2)
//   STABLE_TICKS consecutive disagreeing ticks needed to accept a level (>= 1)
//
// Ports
//   clock    in   1      system clock, rising edge
//   reset_n  in   1      asynchronous active-low reset
//   din      in   WIDTH  raw asynchronous inputs
//   level    out  WIDTH  debounced level per bit (registered)
//   rise     out  WIDTH  one-cycle pulse on a 0->1 change of level
//   fall     out  WIDTH  one-cycle pulse on a 1->0 change of level
//   tick     out  1      one-cycle sample strobe
//
// Build option
//   QA1_INPUT_EDGE_EN  when defined, the rise/fall pulse registers are built.
//                      When undefined, rise and fall are tied to 0. The ports
//                      stay in place and level/tick behave the same way.
// ---------------------------------------------------------------------------
module qa1_input_conditioner #(
  parameter int WIDTH        = 12,
  parameter int TICK_DIV     = 240000,
  parameter int STABLE_TICKS = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = (STABLE_TICKS > 0) ? $clog2(STABLE_TICKS + 1) : 1;
  localparam logic [PW-1:0] PCNT_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_TICKS - 1);

  logic [WIDTH-1:0] s1_reg;
  logic [WIDTH-1:0] s2_reg;
  logic [WIDTH-1:0] level_reg;
  logic [WIDTH-1:0] level_next;
  logic [WIDTH-1:0] accept;
  logic [PW-1:0]    pcnt_reg;
  logic [PW-1:0]    pcnt_next;
  logic [CW-1:0]    cnt_reg  [WIDTH];
  logic [CW-1:0]    cnt_next [WIDTH];

  // Two-flop synchroniser; only s2_reg is used downstream.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_reg <= '0;
      s2_reg <= '0;
    end else begin
      s1_reg <= din;
      s2_reg <= s1_reg;
    end
  end

  // Shared prescaler. tick is decoded straight from the counter register, so
  // it is high for exactly the one cycle before the wrap.
  assign tick      = (pcnt_reg == PCNT_LAST);
  assign pcnt_next = tick ? '0 : pcnt_reg + 1'b1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pcnt_reg <= '0;
    end else begin
      pcnt_reg <= pcnt_next;
    end
  end

  // Per-bit debounce. cnt_reg counts the disagreeing ticks seen so far. The
  // tick that would make the run STABLE_TICKS long accepts the new level
  // instead of incrementing. Any agreeing tick throws away a partial run.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    logic differ;

    assign differ         = s2_reg[gi] ^ level_reg[gi];
    assign accept[gi]     = tick & differ & (cnt_reg[gi] == CNT_LAST);
    assign level_next[gi] = accept[gi] ? s2_reg[gi] : level_reg[gi];
    assign cnt_next[gi]   = !tick                     ? cnt_reg[gi] :
                            (!differ || accept[gi])   ? '0          :
                                                        cnt_reg[gi] + 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      level_reg <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_reg[i] <= '0;
      end
    end else begin
      level_reg <= level_next;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_reg[i] <= cnt_next[i];
      end
    end
  end

  assign level = level_reg;

`ifdef QA1_INPUT_EDGE_EN
  // Pulses are registered on the same edge as level, so each one lines up
  // with the first cycle of the new level value. accept is only ever set on
  // tick edges, so the pulses drop back to 0 on the following edge.
  logic [WIDTH-1:0] rise_reg;
  logic [WIDTH-1:0] fall_reg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rise_reg <= '0;
      fall_reg <= '0;
    end else begin
      rise_reg <= accept & s2_reg;
      fall_reg <= accept & ~s2_reg;
    end
  end

  assign rise = rise_reg;
  assign fall = fall_reg;
`else
  assign rise = '0;
  assign fall = '0;
`endif

endmodule

// File: tb/tb_qa1_input_conditioner.sv
// ---------------------------------------------------------------------------
// tb_qa1_input_conditioner
//
// Directed and random stimulus for qa1_input_conditioner with WIDTH=4,
// TICK_DIV=4, STABLE_TICKS=3. The reference model works at the level of the
// debounce rule: it keeps the list of values seen at sample ticks, and a bit
// flips when its last STABLE_TICKS tick samples all disagree with the level.
// Expected pulses follow the build option (zero when edges are not built).
// ---------------------------------------------------------------------------
module tb_qa1_input_conditioner;

  localparam int W  = 4;
  localparam int TD = 4;
  localparam int ST = 3;

  logic         clock = 1'b0;
  logic         reset_n;
  logic [W-1:0] din;
  logic [W-1:0] level;
  logic [W-1:0] rise;
  logic [W-1:0] fall;
  logic         tick;

  int checks = 0;
  int errors = 0;

  qa1_input_conditioner #(
    .WIDTH       (W),
    .TICK_DIV    (TD),
    .STABLE_TICKS(ST)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .din    (din),
    .level  (level),
    .rise   (rise),
    .fall   (fall),
    .tick   (tick)
  );

  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  int           m_edges;       // rising edges since reset release
  logic [W-1:0] m_din_hist[$]; // din captured at recent edges (zero-padded)
  logic [W-1:0] m_tick_s[$];   // synchronised value seen at each tick edge
  logic [W-1:0] m_level;
  logic [W-1:0] m_rise;
  logic [W-1:0] m_fall;

  task automatic model_reset();
    m_edges = 0;
    m_din_hist.delete();
    m_din_hist.push_back('0);
    m_din_hist.push_back('0);
    m_tick_s.delete();
    m_level = '0;
    m_rise  = '0;
    m_fall  = '0;
  endtask

  task automatic model_edge(input logic [W-1:0] d);
    logic [W-1:0] seen;
    int           n;
    bit           all_differ;
    logic [W-1:0] old_level;
    // The value the debouncer sees now is din from two edges earlier.
    seen = m_din_hist[m_din_hist.size() - 2];
    m_din_hist.push_back(d);
    if (m_din_hist.size() > 3) void'(m_din_hist.pop_front());
    m_edges++;
    m_rise = '0;
    m_fall = '0;
    if (m_edges % TD == 0) begin
      m_tick_s.push_back(seen);
      n = m_tick_s.size();
      old_level = m_level;
      for (int b = 0; b < W; b++) begin
        all_differ = (n >= ST);
        for (int k = 0; k < ST && all_differ; k++) begin
          if (m_tick_s[n - 1 - k][b] == old_level[b]) all_differ = 0;
        end
        if (all_differ) begin
          m_level[b] = ~old_level[b];
          if (m_level[b]) m_rise[b] = 1'b1;
          else            m_fall[b] = 1'b1;
        end
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic check_all(input string tag);
    logic [W-1:0] exp_rise;
    logic [W-1:0] exp_fall;
    logic         exp_tick;
`ifdef QA1_INPUT_EDGE_EN
    exp_rise = m_rise;
    exp_fall = m_fall;
`else
    exp_rise = '0;
    exp_fall = '0;
`endif
    exp_tick = reset_n && ((m_edges + 1) % TD == 0);
    checks++;
    assert (level === m_level) else begin
      errors++;
      $error("FAIL %s level got %b exp %b (edge %0d)", tag, level, m_level, m_edges);
    end
    checks++;
    assert (rise === exp_rise) else begin
      errors++;
      $error("FAIL %s rise got %b exp %b (edge %0d)", tag, rise, exp_rise, m_edges);
    end
    checks++;
    assert (fall === exp_fall) else begin
      errors++;
      $error("FAIL %s fall got %b exp %b (edge %0d)", tag, fall, exp_fall, m_edges);
    end
    checks++;
    assert (tick === exp_tick) else begin
      errors++;
      $error("FAIL %s tick got %b exp %b (edge %0d)", tag, tick, exp_tick, m_edges);
    end
  endtask

  // Directed check against a value written straight from the test plan.
  task automatic check_level(input string tag, input logic [W-1:0] exp);
    checks++;
    assert (level === exp) else begin
      errors++;
      $error("FAIL %s level got %b exp %b", tag, level, exp);
    end
  endtask

  // One clock edge: din is held across the edge, outputs sampled 1 ns later.
  task automatic step(input string tag);
    logic [W-1:0] d;
    logic         r;
    d = din;
    r = reset_n;
    @(posedge clock);
    #1;
    if (r) model_edge(d);
    check_all(tag);
  endtask

  task automatic steps(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] flip;

    reset_n = 1'b0;
    din     = '0;
    model_reset();
    #2;
    check_all("reset");
    steps("reset", 2);

    // Clean step: din=0001 held from release; accepted on edge 12.
    din     = 4'b0001;
    reset_n = 1'b1;
    steps("clean", 11);
    check_level("clean_e11", 4'b0000);
    step("clean");
    check_level("clean_e12", 4'b0001);
    step("clean");
    $display("clean step: level=%b rise=%b at edge %0d", level, rise, m_edges);

    // Glitch: din[1] high for 5 cycles only.
    steps("settle", 3);
    din[1] = 1'b1;
    steps("glitch", 5);
    din[1] = 1'b0;
    steps("glitch", 20);
    check_level("glitch", 4'b0001);
    $display("glitch: level=%b", level);

    // Bounce: toggle din[2] every tick period for 20 cycles, then hold high.
    for (int i = 0; i < 5; i++) begin
      din[2] = ~din[2];
      steps("bounce", TD);
    end
    din[2] = 1'b1;
    steps("bounce_hold", 20);
    check_level("bounce", 4'b0101);
    $display("bounce: level=%b", level);

    // Simultaneous changes: 0011 -> 1100.
    din = 4'b0011;
    steps("simul_a", 16);
    check_level("simul_a", 4'b0011);
    din = 4'b1100;
    steps("simul_b", 16);
    check_level("simul_b", 4'b1100);
    $display("simultaneous: level=%b", level);

    // Reset mid-operation with level=1111.
    din = 4'b1111;
    steps("pre_reset", 16);
    check_level("pre_reset", 4'b1111);
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    check_level("async_reset", 4'b0000);
    step("in_reset");
    reset_n = 1'b1;
    steps("post_reset", 11);
    check_level("post_reset_e11", 4'b0000);
    step("post_reset");
    check_level("post_reset_e12", 4'b1111);
    $display("reset mid-op: level=%b at edge %0d", level, m_edges);

    // Random: each bit flips with probability 1/16 per cycle.
    for (int i = 0; i < 800; i++) begin
      flip = '0;
      for (int b = 0; b < W; b++) flip[b] = ($urandom_range(0, 15) == 0);
      din = din ^ flip;
      step("random");
    end
    $display("random: final level=%b din=%b", level, din);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/qa1_input_conditioner.md
# qa1_input_conditioner

Upstream input stage for the qa1 switch/button display logic on the Tang Primer board. It takes the raw, asynchronous toggle switches and push buttons and synchronises each one to `clock`. It then debounces each bit independently and presents clean levels, plus optional one-cycle rise/fall pulses, to the 7-segment and green LED decode stage. All bits are handled identically and share one sample-tick prescaler.

## Interface
- `WIDTH`, 12, number of conditioned inputs (8 switches + 4 buttons concatenated by the parent)
- `TICK_DIV`, 240000, clock cycles per sample tick (10 ms at 24 MHz); legal range ≥ 2
- `STABLE_TICKS`, 2, consecutive disagreeing ticks required to accept a new level; legal range ≥ 1
- `clock`  in  1  system clock, rising-edge
- `reset_n`  in  1  reset, asynchronous and active-low
- `din`  in  WIDTH  raw asynchronous inputs
- `level`  out  WIDTH  debounced level per bit, registered
- `rise`  out  WIDTH  one-cycle pulse on a 0→1 change of `level`
- `fall`  out  WIDTH  one-cycle pulse on a 1→0 change of `level`
- `tick`  out  1  one-cycle sample strobe, exported for the parent's use

## Operation
- **Synchroniser:** two flops per bit, `din` → `s1` → `s2`. Only `s2` is used downstream.
- **Prescaler:**
  - `pcnt` counts 0..TICK_DIV-1 and wraps to 0.
  - `tick` is 1 while `pcnt == TICK_DIV-1`.
  - Width is clog2(TICK_DIV).
- **Per-bit debounce counter:**
  - Each bit has a counter `cnt[i]` of width clog2(STABLE_TICKS+1).
  - Counters are updated only on clock edges where `tick` = 1.
- **Tick edge, `s2[i] == level[i]`:** `cnt[i]` ← 0.
- **Tick edge, `s2[i] != level[i]` and `cnt[i] == STABLE_TICKS-1`:**
  - `level[i]` ← `s2[i]` and `cnt[i]` ← 0.
  - `rise[i]` or `fall[i]` ← 1 for one cycle, matching the direction of the change.
- **Tick edge, `s2[i] != level[i]` otherwise:** `cnt[i]` ← `cnt[i]`+1.
- **Non-tick edges:** `cnt` and `level` hold. `rise`/`fall` ← 0.
- **Bounce handling:** any tick on which the input agrees with `level` discards the partial count. Only an uninterrupted run of STABLE_TICKS disagreeing samples is accepted.
- **Independence:** bits are independent. Any subset may change level on the same tick edge, each with its own pulse.
- **STABLE_TICKS = 1:** the first disagreeing tick flips `level`.

## Timing
- **Reset (`reset_n` low, immediate and asynchronous):**
  - `s1`, `s2`, `pcnt`, `cnt` = 0.
  - `level`, `rise`, `fall`, `tick` = 0.
- **Reset mid-operation:**
  - Any bit with `level` = 1 drops to 0 with no `fall` pulse.
  - All partial counts are lost.
- **Tick schedule:** after reset release, the first tick edge is rising edge number TICK_DIV. Subsequent tick edges follow every TICK_DIV edges.
- **Latency from a clean `din` step to `level`/pulse:** minimum 2 + (STABLE_TICKS-1)·TICK_DIV + 1 edges, maximum 2 + STABLE_TICKS·TICK_DIV edges.
- **Glitch rejection:** an input excursion spanning fewer than STABLE_TICKS tick edges never changes `level`.
- **Pulse alignment:** `rise`/`fall` are registered in the same edge as `level`. The pulse is high exactly for the first cycle of the new `level` value.
- **Pipelining:** no handshake and no backpressure. Outputs are valid every cycle.

## Configuration
- **Macro:** `QA1_INPUT_EDGE_EN`.
- **Defined:** the `rise`/`fall` pulse registers are implemented as described above.
- **Undefined:**
  - The pulse registers are not built.
  - `rise` and `fall` are tied to 0.
  - Ports remain, so the parent is unchanged.
  - `level` and `tick` behaviour is identical in both builds.

## Test plan
Bench parameters: WIDTH=4, TICK_DIV=4, STABLE_TICKS=3.
- **Clean step:** release reset with `din`=4'b0001 held.
  - Tick edges at 4, 8, 12.
  - `level[0]`=1 and `rise[0]`=1 at edge 12, with `rise[0]`=0 again at edge 13.
  - Other bits stay 0.
- **Glitch:** with `level`=0, drive `din[1]`=1 for 5 cycles, then 0.
  - `level[1]` never changes.
  - No `rise`.
- **Bounce:** toggle `din[2]` on alternate ticks for 20 cycles, then hold at 1.
  - No change during bouncing.
  - `level[2]`=1 exactly 3 tick edges after the last change is captured in `s2`.
- **Simultaneous changes:** `din` 4'b0011 → 4'b1100 with `level`=4'b0011.
  - On one edge, `level`=4'b1100, `rise`=4'b1100, `fall`=4'b0011.
- **Reset mid-operation:** drive `reset_n` low for 1 cycle while `level`=4'b1111.
  - `level`=0 immediately with no `fall`.
  - With `din` still 4'b1111, `level` returns at edge 12 after release.
- **Build without `QA1_INPUT_EDGE_EN`:** repeat the clean-step test.
  - `level` timing is identical.
  - `rise` and `fall` stay 0 throughout.
